// File: rtl/quad_input_filter_if.sv
// Encoder-pin conditioning bus: raw pins and filter configuration in, clean levels and diagnostics out.
interface quad_input_filter_if #(
  parameter int FILT_W  = 4,
  parameter int PRESC_W = 8
);
  logic               a_raw;
  logic               b_raw;
  logic [FILT_W-1:0]  filt_len;
  logic [PRESC_W-1:0] presc;
  logic               glitch_clr;
  logic               a;
  logic               b;
  logic               edge_pulse;
  logic               both_err;
  logic [7:0]         glitch_cnt;

  modport master (
    output a_raw, b_raw, filt_len, presc, glitch_clr,
    input  a, b, edge_pulse, both_err, glitch_cnt
  );

  modport slave (
    input  a_raw, b_raw, filt_len, presc, glitch_clr,
    output a, b, edge_pulse, both_err, glitch_cnt
  );
endinterface

// File: rtl/quad_input_filter.sv
// Synchronises and debounces quadrature encoder pins ahead of the decoder FSM.
// state   | meaning
// STABLE  | output matches the accepted level, no candidate level pending
// PENDING | sampled level differs from output, counting ticks it has held
module quad_input_filter #(
  parameter int FILT_W  = 4,
  parameter int PRESC_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  quad_input_filter_if.slave  bus
);

  typedef enum logic {STABLE, PENDING} filt_state_t;

  logic [1:0]         sync1_q;
  logic [1:0]         s_q;
  logic [PRESC_W-1:0] pcnt_q;
  logic               tick;
  logic [1:0]         out_v;
  logic [1:0]         upd_v;
  logic [1:0]         glitch_v;
  logic               edge_q;
  logic               both_q;
  logic [7:0]         gcnt_q;
  logic [8:0]         gsum;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= {bus.b_raw, bus.a_raw};
      s_q     <= sync1_q;
    end
  end

  // The >= compare lets a lowered presc take effect without waiting for a wrap.
  assign tick = (pcnt_q >= bus.presc);

  always_ff @(posedge clk) begin
    if (!reset_n) pcnt_q <= '0;
    else if (tick) pcnt_q <= '0;
    else pcnt_q <= pcnt_q + PRESC_W'(1);
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    filt_state_t       state_q, state_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              upd, glitch;
    logic [FILT_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + {{FILT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      upd     = 1'b0;
      glitch  = 1'b0;
      if (tick) begin
        case (state_q)
          STABLE: begin
            if (s_q[ch] != out_q) begin
              if (bus.filt_len <= FILT_W'(1)) begin
                out_d = s_q[ch];
                upd   = 1'b1;
              end else begin
                cnt_d   = FILT_W'(1);
                state_d = PENDING;
              end
            end
          end
          PENDING: begin
            if (s_q[ch] == out_q) begin
              state_d = STABLE;
              cnt_d   = '0;
              glitch  = 1'b1;
            end else if (cnt_inc >= {1'b0, bus.filt_len}) begin
              out_d   = s_q[ch];
              cnt_d   = '0;
              state_d = STABLE;
              upd     = 1'b1;
            end else if (cnt_q != {FILT_W{1'b1}}) begin
              cnt_d = cnt_inc[FILT_W-1:0];
            end
          end
          default: begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign out_v[ch]    = out_q;
    assign upd_v[ch]    = upd;
    assign glitch_v[ch] = glitch;
  end

  assign gsum = {1'b0, gcnt_q} + {8'b0, glitch_v[0]} + {8'b0, glitch_v[1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_q <= 1'b0;
      both_q <= 1'b0;
      gcnt_q <= '0;
    end else begin
      edge_q <= |upd_v;
      both_q <= &upd_v;
      if (bus.glitch_clr) gcnt_q <= '0;
      else if (gsum > 9'd255) gcnt_q <= 8'd255;
      else gcnt_q <= gsum[7:0];
    end
  end

  assign bus.a          = out_v[0];
  assign bus.b          = out_v[1];
  assign bus.edge_pulse = edge_q;
  assign bus.both_err   = both_q;
  assign bus.glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_quad_input_filter.sv
// Bench for quad_input_filter: directed scenarios plus randomized pin activity against a behavioural model.
module tb_quad_input_filter;
  localparam int FILT_W  = 4;
  localparam int PRESC_W = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  quad_input_filter_if #(.FILT_W(FILT_W), .PRESC_W(PRESC_W)) bus ();

  quad_input_filter #(.FILT_W(FILT_W), .PRESC_W(PRESC_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference: pins reach the filter two clocks late, a sample is
  // taken every presc+1 clocks, and a new level wins after max(filt_len,1)
  // consecutive differing samples; a sample agreeing with the output part-way
  // through a run is a rejected pulse.
  bit m_sync1 [2];
  bit m_s     [2];
  bit m_out   [2];
  int m_run   [2];
  int m_since;
  bit m_edge, m_both;
  int m_gcnt;

  always @(posedge clk) begin : ref_model
    int fl, ups, gls;
    bit tk;
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        m_sync1[c] = 0; m_s[c] = 0; m_out[c] = 0; m_run[c] = 0;
      end
      m_since = 0; m_edge = 0; m_both = 0; m_gcnt = 0;
    end else begin
      fl = (bus.filt_len == 0) ? 1 : int'(bus.filt_len);
      tk = (m_since >= int'(bus.presc));
      m_since = tk ? 0 : m_since + 1;
      ups = 0; gls = 0;
      for (int c = 0; c < 2; c++) begin
        if (tk) begin
          if (m_s[c] != m_out[c]) begin
            m_run[c]++;
            if (m_run[c] >= fl) begin
              m_out[c] = m_s[c];
              m_run[c] = 0;
              ups++;
            end
          end else if (m_run[c] > 0) begin
            gls++;
            m_run[c] = 0;
          end
        end
      end
      m_edge = (ups > 0);
      m_both = (ups == 2);
      if (bus.glitch_clr) m_gcnt = 0;
      else m_gcnt = (m_gcnt + gls > 255) ? 255 : m_gcnt + gls;
      m_s[0] = m_sync1[0]; m_s[1] = m_sync1[1];
      m_sync1[0] = bus.a_raw; m_sync1[1] = bus.b_raw;
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int rise;
    bus.a_raw = 1; bus.b_raw = 1; bus.filt_len = 3; bus.presc = 0; bus.glitch_clr = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.a, bus.b, bus.edge_pulse, bus.both_err, bus.glitch_cnt} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got a=%b b=%b edge=%b both=%b gcnt=%0d want all 0",
                 i, bus.a, bus.b, bus.edge_pulse, bus.both_err, bus.glitch_cnt);
      end
    end
    reset_n = 1'b1;
    rise = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rise == 0 && bus.a === 1'b1) rise = i;
    end
    n_cmp++;
    if (rise != 5) begin
      n_err++;
      $display("FAIL reset_release_latency got edge %0d want edge 5", rise);
    end
  endtask

  task automatic test_latency();
    bus.a_raw = 0; bus.b_raw = 0; bus.filt_len = 3; bus.presc = 0;
    apply_reset();
    repeat (4) @(negedge clk);
    bus.a_raw = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.a !== (i >= 5) || bus.edge_pulse !== (i == 5) || bus.b !== 1'b0) begin
        n_err++;
        $display("FAIL latency edge=%0d got a=%b pulse=%b b=%b want a=%b pulse=%b b=0",
                 i, bus.a, bus.edge_pulse, bus.b, (i >= 5), (i == 5));
      end
    end
  endtask

  task automatic test_glitch();
    bus.a_raw = 0; bus.b_raw = 0; bus.filt_len = 4; bus.presc = 0;
    apply_reset();
    repeat (3) @(negedge clk);
    for (int r = 0; r < 300; r++) begin
      bus.a_raw = 1;
      repeat (3) @(negedge clk);
      bus.a_raw = 0;
      repeat (4) @(negedge clk);
      if (r == 0) begin
        n_cmp++;
        if (bus.glitch_cnt !== 8'd1 || bus.a !== 1'b0) begin
          n_err++;
          $display("FAIL glitch_first got gcnt=%0d a=%b want gcnt=1 a=0", bus.glitch_cnt, bus.a);
        end
      end
    end
    n_cmp++;
    if (bus.glitch_cnt !== 8'd255 || bus.a !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_saturate got gcnt=%0d a=%b want gcnt=255 a=0", bus.glitch_cnt, bus.a);
    end
    bus.a_raw = 1;
    repeat (3) @(negedge clk);
    bus.a_raw = 0;
    repeat (2) @(negedge clk);
    bus.glitch_clr = 1;
    @(negedge clk);
    bus.glitch_clr = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.glitch_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL glitch_clr_priority got gcnt=%0d want 0", bus.glitch_cnt);
    end
    bus.a_raw = 1; bus.b_raw = 1;
    repeat (3) @(negedge clk);
    bus.a_raw = 0; bus.b_raw = 0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.glitch_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL glitch_double got gcnt=%0d want 2", bus.glitch_cnt);
    end
  endtask

  task automatic test_prescaler();
    int  rise;
    bit  seen;
    bus.a_raw = 0; bus.b_raw = 0; bus.filt_len = 2; bus.presc = 9;
    apply_reset();
    bus.b_raw = 1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.b === 1'b1) seen = 1;
    end
    bus.b_raw = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.b === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL presc_short_pulse got b rose want b stays 0");
    end
    bus.b_raw = 1;
    rise = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rise == 0 && bus.b === 1'b1) rise = i;
    end
    n_cmp++;
    if (rise == 0 || rise > 22) begin
      n_err++;
      $display("FAIL presc_hold_rise got edge %0d want 1..22", rise);
    end
    bus.b_raw = 0; bus.filt_len = 1; bus.presc = 9;
    apply_reset();
    bus.b_raw = 1;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (bus.b !== 1'b0) begin
      n_err++;
      $display("FAIL presc_before_cut got b=%b want 0", bus.b);
    end
    bus.presc = 0;
    @(negedge clk);
    n_cmp++;
    if (bus.b !== 1'b1) begin
      n_err++;
      $display("FAIL presc_cut_tick got b=%b want 1", bus.b);
    end
  endtask

  task automatic test_simultaneous();
    bus.a_raw = 0; bus.b_raw = 0; bus.filt_len = 2; bus.presc = 0;
    apply_reset();
    repeat (3) @(negedge clk);
    bus.a_raw = 1; bus.b_raw = 1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.a !== (i >= 4) || bus.b !== (i >= 4) ||
          bus.edge_pulse !== (i == 4) || bus.both_err !== (i == 4)) begin
        n_err++;
        $display("FAIL simultaneous edge=%0d got a=%b b=%b pulse=%b both=%b want a=b=%b pulse=both=%b",
                 i, bus.a, bus.b, bus.edge_pulse, bus.both_err, (i >= 4), (i == 4));
      end
    end
  endtask

  task automatic test_quad_sweep();
    logic [1:0] seq [4];
    int pulses, boths;
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    bus.a_raw = 0; bus.b_raw = 0; bus.filt_len = 3; bus.presc = 0;
    apply_reset();
    repeat (5) @(negedge clk);
    boths = 0;
    for (int st = 0; st < 4; st++) begin
      bus.a_raw = seq[st][1]; bus.b_raw = seq[st][0];
      pulses = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.edge_pulse === 1'b1) pulses++;
        if (bus.both_err !== 1'b0) boths++;
      end
      n_cmp++;
      if (pulses != 1 || {bus.a, bus.b} !== seq[st]) begin
        n_err++;
        $display("FAIL quad_step%0d got pulses=%0d ab=%b%b want pulses=1 ab=%b",
                 st, pulses, bus.a, bus.b, seq[st]);
      end
    end
    n_cmp++;
    if (boths != 0 || bus.glitch_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL quad_clean got both_cycles=%0d gcnt=%0d want 0 and 0", boths, bus.glitch_cnt);
    end
  endtask

  task automatic test_random();
    int hold_a, hold_b;
    logic [11:0] obs, exp_v;
    bus.glitch_clr = 0;
    hold_a = 1; hold_b = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      obs   = {bus.a, bus.b, bus.edge_pulse, bus.both_err, bus.glitch_cnt};
      exp_v = {m_out[0], m_out[1], m_edge, m_both, 8'(m_gcnt)};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL random cyc=%0d got a,b,edge,both,gcnt=%b,%b,%b,%b,%0d want %b,%b,%b,%b,%0d",
                 cyc, obs[11], obs[10], obs[9], obs[8], obs[7:0],
                 exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
      if (cyc % 250 == 0) begin
        bus.filt_len = FILT_W'($urandom_range(0, 15));
        bus.presc    = PRESC_W'($urandom_range(0, 3));
      end
      if (--hold_a <= 0) begin
        bus.a_raw = 1'($urandom_range(0, 1));
        hold_a = $urandom_range(1, 10);
      end
      if (--hold_b <= 0) begin
        bus.b_raw = 1'($urandom_range(0, 1));
        hold_b = $urandom_range(1, 10);
      end
      bus.glitch_clr = ($urandom_range(0, 59) == 0);
    end
    bus.glitch_clr = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.a_raw = 0; bus.b_raw = 0; bus.filt_len = 3; bus.presc = 0; bus.glitch_clr = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_prescaler();
    test_simultaneous();
    test_quad_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
